// File: rtl/gte_micro_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gte_micro_sequencer_pkg
// Purpose  : Shared GTE definitions: sequencer states, command fields, PC width.
// Revision : 1.0 - initial release
// ============================================================================
package gte_micro_sequencer_pkg;

    localparam int c_PC_W     = 9;
    localparam int c_CMD_W    = 25;
    localparam int c_OPCODE_W = 6;

    localparam logic [c_PC_W-1:0] c_PC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [c_OPCODE_W-1:0] opcode;
        logic                  sf;
        logic [1:0]            mx;
        logic [1:0]            vsel;
        logic [1:0]            cv;
        logic                  lm;
    } cmd_fields_t;

endpackage
`default_nettype wire

// File: rtl/gte_micro_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : gte_micro_sequencer_if
// Purpose  : CPU command handshake, microcode-store flags and latched fields.
// Revision : 1.0 - initial release
// ============================================================================
interface gte_micro_sequencer_if;
    import gte_micro_sequencer_pkg::*;

    logic                  i_cmdValid;
    logic [c_CMD_W-1:0]    i_cmd;
    logic                  o_cmdReady;
    logic                  i_stall;
    logic                  i_lastInstr;
    logic [c_PC_W-1:0]     o_PC;
    logic                  o_execValid;
    logic [c_OPCODE_W-1:0] o_opcode;
    logic                  o_sf;
    logic [1:0]            o_mx;
    logic [1:0]            o_vsel;
    logic [1:0]            o_cv;
    logic                  o_lm;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_cmdValid, i_cmd, i_stall, i_lastInstr,
        input  o_cmdReady, o_PC, o_execValid, o_opcode, o_sf, o_mx,
               o_vsel, o_cv, o_lm, o_busy, o_done, o_err
    );

    modport slave (
        input  i_cmdValid, i_cmd, i_stall, i_lastInstr,
        output o_cmdReady, o_PC, o_execValid, o_opcode, o_sf, o_mx,
               o_vsel, o_cv, o_lm, o_busy, o_done, o_err
    );

endinterface
`default_nettype wire

// File: rtl/gte_start_pc_rom.sv
`default_nettype none
// ============================================================================
// Module   : gte_start_pc_rom
// Purpose  : Opcode to microcode start address; built with the microcode image.
// Revision : 1.0 - initial release
// ============================================================================
module gte_start_pc_rom
    import gte_micro_sequencer_pkg::*;
(
    input  wire logic [c_OPCODE_W-1:0] i_opcode,
    output logic      [c_PC_W-1:0]     o_start_pc
);

    // Zero marks an unimplemented opcode.
    always_comb begin
        o_start_pc = '0;
        case (i_opcode)
            6'h01:   o_start_pc = 9'd16;
            6'h02:   o_start_pc = 9'd508;
            6'h06:   o_start_pc = 9'd32;
            6'h0C:   o_start_pc = 9'd48;
            default: o_start_pc = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gte_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gte_micro_sequencer
// Purpose  : COP2 command accept and microcode PC sequencing with stall replay.
// Revision : 1.0 - initial release
// ============================================================================
module gte_micro_sequencer
    import gte_micro_sequencer_pkg::*;
(
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    gte_micro_sequencer_if.slave bus
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [c_PC_W-1:0]   r_pc;
    logic [c_PC_W-1:0]   w_pc_nxt;
    logic [c_PC_W-1:0]   w_start_pc;
    cmd_fields_t         r_fields;
    cmd_fields_t         w_cmd_fields;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_cmd_ready;
    logic                w_exec_valid;
    logic                w_finish;
    logic                w_unused_cmd_bits;

    gte_start_pc_rom u_start_pc_rom (
        .i_opcode   (bus.i_cmd[5:0]),
        .o_start_pc (w_start_pc)
    );

    always_comb begin
        w_cmd_fields        = '0;
        w_cmd_fields.opcode = bus.i_cmd[5:0];
        w_cmd_fields.lm     = bus.i_cmd[10];
        w_cmd_fields.cv     = bus.i_cmd[14:13];
        w_cmd_fields.vsel   = bus.i_cmd[16:15];
        w_cmd_fields.mx     = bus.i_cmd[18:17];
        w_cmd_fields.sf     = bus.i_cmd[19];
    end

    assign w_unused_cmd_bits = ^{bus.i_cmd[24:20], bus.i_cmd[12:11], bus.i_cmd[9:6]};

    // The store only yields entry p after visiting p-1, so a stalled entry is
    // replayed by stepping back one address through WAIT.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_cmd_ready  = 1'b0;
        w_exec_valid = 1'b0;
        w_finish     = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_pc_nxt    = '0;
            end
            ST_WAIT: begin
                if (!bus.i_stall) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = r_pc + 9'd1;
                end
            end
            ST_RUN: begin
                w_exec_valid = !bus.i_stall;
                if (bus.i_stall) begin
                    w_state_nxt = ST_WAIT;
                    w_pc_nxt    = r_pc - 9'd1;
                end else if (bus.i_lastInstr) begin
                    w_cmd_ready = 1'b1;
                    w_finish    = 1'b1;
                end else if (r_pc == c_PC_MAX) begin
                    w_finish  = 1'b1;
                    w_err_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + 9'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
            end
        endcase

        if (w_finish) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = '0;
            w_done_nxt  = 1'b1;
        end

        // An accept in the finishing cycle overrides the return to IDLE.
        w_accept = w_cmd_ready && bus.i_cmdValid;
        if (w_accept) begin
            w_err_nxt = 1'b0;
            if (w_start_pc != '0) begin
                w_state_nxt = ST_WAIT;
                w_pc_nxt    = w_start_pc;
            end else begin
                w_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_fields <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_fields <= w_cmd_fields;
            end
        end
    end

    assign bus.o_cmdReady  = w_cmd_ready;
    assign bus.o_PC        = r_pc;
    assign bus.o_execValid = w_exec_valid;
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_done      = r_done;
    assign bus.o_err       = r_err;
    assign bus.o_opcode    = r_fields.opcode;
    assign bus.o_sf        = r_fields.sf;
    assign bus.o_mx        = r_fields.mx;
    assign bus.o_vsel      = r_fields.vsel;
    assign bus.o_cv        = r_fields.cv;
    assign bus.o_lm        = r_fields.lm;

endmodule
`default_nettype wire

// File: tb/tb_gte_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gte_micro_sequencer
// Purpose  : Directed self-checking bench for the GTE microcode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gte_micro_sequencer;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    gte_micro_sequencer_if bus ();

    gte_micro_sequencer dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Microcode image: the program at 16 ends at 19; the one at 508 never ends.
    assign bus.i_lastInstr = (bus.o_PC == 9'd19);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input int pc, input int ev, input int busy,
                       input int rdy, input int done);
        #1;
        chk({tag, ".pc"},   32'(bus.o_PC),        32'(pc));
        chk({tag, ".ev"},   32'(bus.o_execValid), 32'(ev));
        chk({tag, ".busy"}, 32'(bus.o_busy),      32'(busy));
        chk({tag, ".rdy"},  32'(bus.o_cmdReady),  32'(rdy));
        chk({tag, ".done"}, 32'(bus.o_done),      32'(done));
    endtask

    task automatic fld(input string tag, input int op, input int sf, input int mx,
                       input int vsel, input int cv, input int lm);
        chk({tag, ".opcode"}, 32'(bus.o_opcode), 32'(op));
        chk({tag, ".sf"},     32'(bus.o_sf),     32'(sf));
        chk({tag, ".mx"},     32'(bus.o_mx),     32'(mx));
        chk({tag, ".vsel"},   32'(bus.o_vsel),   32'(vsel));
        chk({tag, ".cv"},     32'(bus.o_cv),     32'(cv));
        chk({tag, ".lm"},     32'(bus.o_lm),     32'(lm));
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        bus.i_cmdValid = 1'b0;
        bus.i_cmd      = '0;
        bus.i_stall    = 1'b0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        cyc("rst", 0, 0, 0, 1, 0);
        chk("rst.err", 32'(bus.o_err), 32'd0);
        fld("rst", 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        tick;

        // Plain run of opcode 0x01, fields with junk in unused bits
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h10DA481;
        cyc("t1.idle", 0, 0, 0, 1, 0);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t1.w16", 16, 0, 1, 0, 0);
        fld("t1", 1, 1, 2, 3, 1, 1);
        tick;
        cyc("t1.r17", 17, 1, 1, 0, 0);
        tick;
        cyc("t1.r18", 18, 1, 1, 0, 0);
        tick;
        cyc("t1.r19", 19, 1, 1, 1, 0);
        tick;

        // Stall replay at 18, then stall coinciding with the last word
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h0000001;
        cyc("t2.idle", 0, 0, 0, 1, 1);
        fld("t1.hold", 1, 1, 2, 3, 1, 1);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t2.w16", 16, 0, 1, 0, 0);
        fld("t2", 1, 0, 0, 0, 0, 0);
        tick;
        cyc("t2.r17", 17, 1, 1, 0, 0);
        tick;
        bus.i_stall = 1'b1;
        cyc("t2.r18s", 18, 0, 1, 0, 0);
        tick;
        cyc("t2.w17a", 17, 0, 1, 0, 0);
        tick;
        bus.i_stall = 1'b0;
        cyc("t2.w17b", 17, 0, 1, 0, 0);
        tick;
        cyc("t2.r18", 18, 1, 1, 0, 0);
        tick;
        bus.i_stall = 1'b1;
        cyc("t2.r19s", 19, 0, 1, 0, 0);
        tick;
        bus.i_stall = 1'b0;
        cyc("t2.w18", 18, 0, 1, 0, 0);
        tick;
        cyc("t2.r19", 19, 1, 1, 1, 0);
        tick;

        // Back-to-back command offered in the last-word cycle
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h0000001;
        cyc("t3.idle", 0, 0, 0, 1, 1);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t3.w16", 16, 0, 1, 0, 0);
        tick;
        cyc("t3.r17", 17, 1, 1, 0, 0);
        tick;
        cyc("t3.r18", 18, 1, 1, 0, 0);
        tick;
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h0000401;
        cyc("t3.r19", 19, 1, 1, 1, 0);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t3.w16b", 16, 0, 1, 0, 1);
        fld("t3", 1, 0, 0, 0, 0, 1);
        tick;
        cyc("t3.r17b", 17, 1, 1, 0, 0);
        tick;
        cyc("t3.r18b", 18, 1, 1, 0, 0);
        tick;
        cyc("t3.r19b", 19, 1, 1, 1, 0);
        tick;

        // Unimplemented opcode
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h000003F;
        cyc("t4.idle", 0, 0, 0, 1, 1);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t4.nop", 0, 0, 0, 1, 1);
        fld("t4", 63, 0, 0, 0, 0, 0);
        tick;

        // PC ceiling: start 508, no last word
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h0000002;
        cyc("t5.idle", 0, 0, 0, 1, 0);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t5.w508", 508, 0, 1, 0, 0);
        chk("t5.err0", 32'(bus.o_err), 32'd0);
        tick;
        cyc("t5.r509", 509, 1, 1, 0, 0);
        tick;
        cyc("t5.r510", 510, 1, 1, 0, 0);
        tick;
        cyc("t5.r511", 511, 1, 1, 0, 0);
        tick;
        cyc("t5.end", 0, 0, 0, 1, 1);
        chk("t5.err1", 32'(bus.o_err), 32'd1);
        tick;

        // Error stays set until the next accept clears it
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h000003F;
        cyc("t6.idle", 0, 0, 0, 1, 0);
        chk("t6.sticky", 32'(bus.o_err), 32'd1);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t6.nop", 0, 0, 0, 1, 1);
        chk("t6.clear", 32'(bus.o_err), 32'd0);
        tick;

        // Asynchronous reset mid-program
        bus.i_cmdValid = 1'b1;
        bus.i_cmd      = 25'h10DA481;
        cyc("t7.idle", 0, 0, 0, 1, 0);
        tick;
        bus.i_cmdValid = 1'b0;
        cyc("t7.w16", 16, 0, 1, 0, 0);
        tick;
        cyc("t7.r17", 17, 1, 1, 0, 0);
        i_rst = 1'b1;
        cyc("t7.rst", 0, 0, 0, 1, 0);
        fld("t7.rst", 0, 0, 0, 0, 0, 0);
        chk("t7.err", 32'(bus.o_err), 32'd0);
        tick;
        i_rst = 1'b0;
        tick;
        cyc("t7.after", 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
